// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage SRAM controller and its helpers.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } mem_state_e;

   localparam int unsigned MEM_BASE_ADDR = 1024;
   localparam int unsigned MEM_SRAM_AW   = 18;
   localparam int unsigned MEM_HW_W      = 16;
   localparam int unsigned MEM_CNT_W     = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with a terminal-count flag; holds at zero until reloaded.
module mem_wait_counter
   import mem_pkg::*;
#(
   parameter int unsigned CNT_W = MEM_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] loadVal_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o,
   output logic             tc_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Load has priority so a phase can restart on the same edge the previous one ends.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = loadVal_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign tc_o    = (count_q == '0);

endmodule

// File: rtl/sram_mem_ctrl.sv
// Memory-stage controller: one 32-bit LDR/STR as two half-word async SRAM phases.
// Optional MEM_ALIGN_CHECK_EN adds mem_misalign and short-circuits unaligned requests.
module sram_mem_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned BASE_ADDR   = MEM_BASE_ADDR,
   parameter int unsigned WAIT_CYCLES = 3,
   parameter int unsigned SRAM_AW     = MEM_SRAM_AW
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rd_en,
   input  logic                wr_en,
   input  logic [31:0]         addr,
   input  logic [31:0]         wdata,
   output logic [31:0]         rdata,
   output logic                ready,
`ifdef MEM_ALIGN_CHECK_EN
   output logic                mem_misalign,
`endif
   output logic [SRAM_AW-1:0]  sram_addr,
   output logic [MEM_HW_W-1:0] sram_dq_out,
   output logic                sram_dq_oe,
   input  logic [MEM_HW_W-1:0] sram_dq_in,
   output logic                sram_we_n
);

   localparam logic [MEM_CNT_W-1:0] PhaseLoad = MEM_CNT_W'(WAIT_CYCLES - 1);

   mem_state_e           state_q, state_d;
   logic                 isWrite_q, isWrite_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [SRAM_AW-1:0]   sramAddr_q, sramAddr_d;
   logic [MEM_HW_W-1:0]  dqOut_q, dqOut_d;
   logic                 dqOe_q, dqOe_d;
   logic                 weN_q, weN_d;
`ifdef MEM_ALIGN_CHECK_EN
   logic                 misalign_q, misalign_d;
`endif

   logic                 cntLoad;
   logic                 cntTc;
   logic [MEM_CNT_W-1:0] unusedCount;
   logic [31:0]          offset;
   logic [SRAM_AW-2:0]   waddr;
   logic                 unusedOffsetBits;

   assign offset           = addr - 32'(BASE_ADDR);
   assign waddr            = offset[SRAM_AW:2];
   assign unusedOffsetBits = ^{offset[31:SRAM_AW+1], offset[1:0]};

   mem_wait_counter #(
      .CNT_W (MEM_CNT_W)
   ) uWaitCounter (
      .clk_i     (clk),
      .rst_i     (rst),
      .load_i    (cntLoad),
      .loadVal_i (PhaseLoad),
      .en_i      ((state_q == LOW) || (state_q == HIGH)),
      .count_o   (unusedCount),
      .tc_o      (cntTc)
   );

   // Each half-word phase ends on terminal count; read data is captured in the phase's last cycle.
   always_comb begin
      state_d   = state_q;
      isWrite_d = isWrite_q;
      rdata_d   = rdata_q;
      cntLoad   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_d = misalign_q;
`endif
      case (state_q)
         IDLE: begin
            if (rd_en || wr_en) begin
               isWrite_d = wr_en;
               cntLoad   = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
               misalign_d = (addr[1:0] != 2'b00);
               state_d    = (addr[1:0] != 2'b00) ? DONE : LOW;
`else
               state_d = LOW;
`endif
            end
         end
         LOW: begin
            if (cntTc) begin
               state_d = HIGH;
               cntLoad = 1'b1;
               if (!isWrite_q) begin
                  rdata_d[MEM_HW_W-1:0] = sram_dq_in;
               end
            end
         end
         HIGH: begin
            if (cntTc) begin
               state_d = DONE;
               if (!isWrite_q) begin
                  rdata_d[31:MEM_HW_W] = sram_dq_in;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pad outputs are decoded from the next state and registered, so they are glitch-free and
   // aligned with the state they belong to; we_n only ever drops together with oe.
   always_comb begin
      sramAddr_d = '0;
      dqOut_d    = '0;
      dqOe_d     = 1'b0;
      weN_d      = 1'b1;
      if ((state_d == LOW) || (state_d == HIGH)) begin
         sramAddr_d = {waddr, (state_d == HIGH)};
         if (isWrite_d) begin
            weN_d   = 1'b0;
            dqOe_d  = 1'b1;
            dqOut_d = (state_d == HIGH) ? wdata[31:MEM_HW_W] : wdata[MEM_HW_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         isWrite_q  <= 1'b0;
         rdata_q    <= '0;
         sramAddr_q <= '0;
         dqOut_q    <= '0;
         dqOe_q     <= 1'b0;
         weN_q      <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         isWrite_q  <= isWrite_d;
         rdata_q    <= rdata_d;
         sramAddr_q <= sramAddr_d;
         dqOut_q    <= dqOut_d;
         dqOe_q     <= dqOe_d;
         weN_q      <= weN_d;
`ifdef MEM_ALIGN_CHECK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   // A request seen in IDLE is being accepted, so the pipeline must stall from that cycle on.
   assign ready       = (state_q == DONE) || ((state_q == IDLE) && !(rd_en || wr_en));
   assign rdata       = rdata_q;
   assign sram_addr   = sramAddr_q;
   assign sram_dq_out = dqOut_q;
   assign sram_dq_oe  = dqOe_q;
   assign sram_we_n   = weN_q;
`ifdef MEM_ALIGN_CHECK_EN
   assign mem_misalign = (state_q == DONE) && misalign_q;
`endif

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl with a small behavioural async SRAM on the pads.
// Build with MEM_ALIGN_CHECK_EN defined to exercise the misalignment path.
module tb_sram_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;
`ifdef MEM_ALIGN_CHECK_EN
   logic        mem_misalign;
`endif

   int vectors;
   int miscompares;

   logic [15:0] sramMem [0:63];

   sram_mem_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .rd_en       (rd_en),
      .wr_en       (wr_en),
      .addr        (addr),
      .wdata       (wdata),
      .rdata       (rdata),
      .ready       (ready),
`ifdef MEM_ALIGN_CHECK_EN
      .mem_misalign(mem_misalign),
`endif
      .sram_addr   (sram_addr),
      .sram_dq_out (sram_dq_out),
      .sram_dq_oe  (sram_dq_oe),
      .sram_dq_in  (sram_dq_in),
      .sram_we_n   (sram_we_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural SRAM: latches write data while we_n is low, drives reads when the pads are released.
   always @(posedge clk) begin
      if (!sram_we_n) sramMem[sram_addr[5:0]] <= sram_dq_out;
   end
   assign sram_dq_in = sram_dq_oe ? 16'h0000 : sramMem[sram_addr[5:0]];

   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] wd);
      rd_en = rd;
      wr_en = wr;
      addr  = a;
      wdata = wd;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Starts at a falling edge with the controller in IDLE; returns at the falling edge of DONE.
   task automatic doTransfer(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [17:0] expLo,
                             input logic expWrite, input logic [31:0] expRdata);
      applyStimulus(rd, wr, a, wd);
      #1 checkOutput("acceptReady", 32'(ready), 32'h0);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         checkOutput("phaseReady", 32'(ready), 32'h0);
         checkOutput("phaseAddr", 32'(sram_addr), (c <= 3) ? 32'(expLo) : 32'(expLo + 18'd1));
         checkOutput("phaseWeN", 32'(sram_we_n), expWrite ? 32'h0 : 32'h1);
         checkOutput("phaseOe", 32'(sram_dq_oe), expWrite ? 32'h1 : 32'h0);
         if (expWrite)
            checkOutput("phaseDq", 32'(sram_dq_out), (c <= 3) ? 32'(wd[15:0]) : 32'(wd[31:16]));
      end
      @(negedge clk);
      checkOutput("doneReady", 32'(ready), 32'h1);
      checkOutput("doneWeN", 32'(sram_we_n), 32'h1);
      checkOutput("doneOe", 32'(sram_dq_oe), 32'h0);
      checkOutput("doneRdata", rdata, expRdata);
   endtask

   task automatic releaseRequest();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      for (int i = 0; i < 64; i++) sramMem[i] = 16'h0000;
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstRdata", rdata, 32'h0);
      checkOutput("rstAddr", 32'(sram_addr), 32'h0);
      checkOutput("rstDq", 32'(sram_dq_out), 32'h0);
      checkOutput("rstOe", 32'(sram_dq_oe), 32'h0);
      checkOutput("rstWeN", 32'(sram_we_n), 32'h1);
      checkOutput("rstReady", 32'(ready), 32'h1);
      rst = 1'b0;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("idleReady", 32'(ready), 32'h1);
         checkOutput("idleWeN", 32'(sram_we_n), 32'h1);
      end

      doTransfer(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'h0, 1'b1, 32'h0);
      releaseRequest();
      doTransfer(1'b1, 1'b0, 32'd1024, 32'h0, 18'h0, 1'b0, 32'hDEADBEEF);
      releaseRequest();

      doTransfer(1'b0, 1'b1, 32'h440, 32'h12345678, 18'h20, 1'b1, 32'hDEADBEEF);
      releaseRequest();
      doTransfer(1'b1, 1'b0, 32'h440, 32'h0, 18'h20, 1'b0, 32'h12345678);
      // Request held through DONE is a fresh transaction: IDLE cycle must stall again.
      @(negedge clk);
      doTransfer(1'b1, 1'b0, 32'h440, 32'h0, 18'h20, 1'b0, 32'h12345678);
      releaseRequest();

      doTransfer(1'b1, 1'b1, 32'h408, 32'hCAFEF00D, 18'h4, 1'b1, 32'h12345678);
      releaseRequest();
      doTransfer(1'b1, 1'b0, 32'h408, 32'h0, 18'h4, 1'b0, 32'hCAFEF00D);
      releaseRequest();

`ifdef MEM_ALIGN_CHECK_EN
      applyStimulus(1'b1, 1'b0, 32'h402, 32'h0);
      #1 checkOutput("misAcceptReady", 32'(ready), 32'h0);
      checkOutput("misAcceptFlag", 32'(mem_misalign), 32'h0);
      @(negedge clk);
      checkOutput("misReady", 32'(ready), 32'h1);
      checkOutput("misFlag", 32'(mem_misalign), 32'h1);
      checkOutput("misWeN", 32'(sram_we_n), 32'h1);
      checkOutput("misOe", 32'(sram_dq_oe), 32'h0);
      checkOutput("misRdata", rdata, 32'hCAFEF00D);
      releaseRequest();
      checkOutput("misCleared", 32'(mem_misalign), 32'h0);
`else
      doTransfer(1'b1, 1'b0, 32'h442, 32'h0, 18'h20, 1'b0, 32'h12345678);
      releaseRequest();
`endif

      applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0);
      for (int i = 0; i < 4; i++) @(negedge clk);
      checkOutput("midOpInHigh", 32'(sram_addr), 32'h1);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput("midRstWeN", 32'(sram_we_n), 32'h1);
      checkOutput("midRstOe", 32'(sram_dq_oe), 32'h0);
      checkOutput("midRstRdata", rdata, 32'h0);
      checkOutput("midRstAddr", 32'(sram_addr), 32'h0);
      checkOutput("midRstReady", 32'(ready), 32'h1);
      rst = 1'b0;
      @(negedge clk);
      doTransfer(1'b1, 1'b0, 32'd1024, 32'h0, 18'h0, 1'b0, 32'hDEADBEEF);
      releaseRequest();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
